// File: rtl/avalon_addr_pio_pkg.sv
// Register map and CTRL bit positions for the avalon_addr_pio address register block.
// Latency: constants only. Backpressure: n/a.
package avalon_addr_pio_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_STEP  = 2'd1;
    localparam logic [1:0] ADDR_LIMIT = 2'd2;
    localparam logic [1:0] ADDR_CTRL  = 2'd3;

    localparam int CTRL_AUTO_EN = 0;
    localparam int CTRL_WRAP    = 1;
    localparam int CTRL_IRQ_EN  = 2;

    typedef struct packed {
        logic irq_en;
        logic wrap_sticky;
        logic auto_en;
    } ctrl_t;

endpackage

// File: rtl/avalon_addr_pio_step.sv
// Next-address computation: cur + step with a wrap to 0 above limit.
// Latency: combinational. Backpressure: none.
module avalon_addr_pio_step #(
    parameter int WIDTH = 11
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] next,
    output logic             wrapped
);

    logic [WIDTH:0] sum;

    // One extra bit so a carry out of WIDTH counts as exceeding limit.
    always_comb begin
        sum     = {1'b0, cur} + {1'b0, step};
        wrapped = (sum > {1'b0, limit});
        next    = wrapped ? '0 : sum[WIDTH-1:0];
    end

endmodule

// File: rtl/avalon_addr_pio.sv
// Avalon-MM address register with stride auto-advance and wrap at a limit; irq via AVALON_ADDR_PIO_IRQ_EN.
// Latency: writes/advances visible 1 cycle later, reads zero wait states. Backpressure: none, one advance per cycle.
module avalon_addr_pio
    import avalon_addr_pio_pkg::*;
#(
    parameter int               WIDTH       = 11,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic             advance,
    output logic [WIDTH-1:0] out_port,
    output logic             wrap
`ifdef AVALON_ADDR_PIO_IRQ_EN
    ,
    output logic             irq
`endif
);

    logic [WIDTH-1:0] step_reg;
    logic [WIDTH-1:0] limit_reg;
    ctrl_t            ctrl;
    logic             wr;
    logic             wr_data;
    logic             do_adv;
    logic [WIDTH-1:0] adv_next;
    logic             adv_wrapped;
    logic             unused_writedata;

    assign wr      = chipselect && !write_n;
    assign wr_data = wr && (address == ADDR_DATA);
    assign do_adv  = ctrl.auto_en && advance;

    assign unused_writedata = ^writedata[31:WIDTH];

    avalon_addr_pio_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .cur    (out_port),
        .step   (step_reg),
        .limit  (limit_reg),
        .next   (adv_next),
        .wrapped(adv_wrapped)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port  <= RESET_VALUE;
            step_reg  <= WIDTH'(1);
            limit_reg <= '1;
            ctrl      <= '0;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            // A DATA write takes priority and drops a coincident advance entirely.
            if (wr_data) begin
                out_port <= writedata[WIDTH-1:0];
            end else if (do_adv) begin
                out_port <= adv_next;
                wrap     <= adv_wrapped;
            end

            if (wr && address == ADDR_STEP) begin
                step_reg <= writedata[WIDTH-1:0];
            end
            if (wr && address == ADDR_LIMIT) begin
                limit_reg <= writedata[WIDTH-1:0];
            end

            if (wr && address == ADDR_CTRL) begin
                ctrl.auto_en <= writedata[CTRL_AUTO_EN];
                if (writedata[CTRL_WRAP]) begin
                    ctrl.wrap_sticky <= 1'b0;
                end
`ifdef AVALON_ADDR_PIO_IRQ_EN
                ctrl.irq_en <= writedata[CTRL_IRQ_EN];
`endif
            end
            // Placed after the clear so a same-cycle wrap keeps the sticky bit set.
            if (do_adv && !wr_data && adv_wrapped) begin
                ctrl.wrap_sticky <= 1'b1;
            end
        end
    end

`ifdef AVALON_ADDR_PIO_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= ctrl.wrap_sticky & ctrl.irq_en;
        end
    end
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:  readdata[WIDTH-1:0] = out_port;
            ADDR_STEP:  readdata[WIDTH-1:0] = step_reg;
            ADDR_LIMIT: readdata[WIDTH-1:0] = limit_reg;
            default: begin
                readdata[CTRL_AUTO_EN] = ctrl.auto_en;
                readdata[CTRL_WRAP]    = ctrl.wrap_sticky;
                readdata[CTRL_IRQ_EN]  = ctrl.irq_en;
            end
        endcase
    end

endmodule

// File: tb/tb_avalon_addr_pio.sv
// Scoreboarded directed test of avalon_addr_pio (WIDTH=11); irq checks with AVALON_ADDR_PIO_IRQ_EN.
module tb_avalon_addr_pio;

    localparam int SEL_RD   = 0;
    localparam int SEL_OUT  = 1;
    localparam int SEL_WRAP = 2;
    localparam int SEL_IRQ  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        advance;
    logic [10:0] out_port;
    logic        wrap;
    logic        irq;

    avalon_addr_pio #(
        .WIDTH(11),
        .RESET_VALUE(11'd0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .advance   (advance),
        .out_port  (out_port),
        .wrap      (wrap)
`ifdef AVALON_ADDR_PIO_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

`ifndef AVALON_ADDR_PIO_IRQ_EN
    assign irq = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] act;

    always @(posedge clk) cyc++;

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].sel)
                    SEL_RD:   act = readdata;
                    SEL_OUT:  act = {21'd0, out_port};
                    SEL_WRAP: act = {31'd0, wrap};
                    default:  act = {31'd0, irq};
                endcase
                n_checks++;
                if (act !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                             sb[i].name, act, sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push(input int dly, input int sel, input logic [31:0] exp, input string name);
        exp_t e;
        e.cyc  = cyc + dly;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        push(0, SEL_RD, exp, name);
        step_clk();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step_clk();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd2;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        advance    = 1'b0;
        step_clk();
        push(0, SEL_OUT, 32'h0, "reset_out_port");
        push(0, SEL_WRAP, 32'h0, "reset_wrap");
        push(0, SEL_RD, 32'h7FF, "reset_limit_in_reset");
        step_clk();
        reset = 1'b0;
        rd(2'd0, 32'h0, "rst_data");
        rd(2'd1, 32'h1, "rst_step");
        rd(2'd2, 32'h7FF, "rst_limit");
        rd(2'd3, 32'h0, "rst_ctrl");

        // DATA write, upper writedata bits discarded
        wr(2'd0, 32'hFFFF_F123);
        push(0, SEL_OUT, 32'h123, "data_out_port");
        rd(2'd0, 32'h123, "data_read");

        // Back-to-back advances with wrap at limit
        wr(2'd1, 32'h4);
        wr(2'd2, 32'h10);
        wr(2'd3, 32'h1);
        wr(2'd0, 32'h8);
        push(1, SEL_OUT, 32'h0C, "adv1_out");
        push(1, SEL_WRAP, 32'h0, "adv1_wrap");
        push(2, SEL_OUT, 32'h10, "adv2_out");
        push(2, SEL_WRAP, 32'h0, "adv2_wrap");
        push(3, SEL_OUT, 32'h00, "adv3_out");
        push(3, SEL_WRAP, 32'h1, "adv3_wrap");
        push(4, SEL_WRAP, 32'h0, "adv_wrap_one_cycle");
        advance = 1'b1;
        step_clk();
        step_clk();
        step_clk();
        advance = 1'b0;
        rd(2'd3, 32'h3, "ctrl_after_wrap");

        // DATA write beats a coincident advance
        push(1, SEL_OUT, 32'h55, "data_vs_adv_out");
        push(1, SEL_WRAP, 32'h0, "data_vs_adv_wrap");
        advance = 1'b1;
        wr(2'd0, 32'h55);
        advance = 1'b0;

        // Sticky clear coinciding with a wrap: set wins
        wr(2'd3, 32'h3);
        rd(2'd3, 32'h1, "sticky_cleared");
        push(1, SEL_OUT, 32'h0, "clr_vs_wrap_out");
        push(1, SEL_WRAP, 32'h1, "clr_vs_wrap_wrap");
        advance = 1'b1;
        wr(2'd3, 32'h3);
        advance = 1'b0;
        rd(2'd3, 32'h3, "sticky_set_wins");
        wr(2'd3, 32'h3);
        rd(2'd3, 32'h1, "sticky_clear_later");

        // STEP write with advance uses old stride
        push(1, SEL_OUT, 32'h4, "step_wr_old_value");
        advance = 1'b1;
        wr(2'd1, 32'h8);
        push(1, SEL_OUT, 32'hC, "step_wr_new_value");
        step_clk();
        advance = 1'b0;

        // advance ignored when auto_en is clear
        wr(2'd3, 32'h0);
        push(1, SEL_OUT, 32'hC, "adv_disabled_out");
        push(1, SEL_WRAP, 32'h0, "adv_disabled_wrap");
        advance = 1'b1;
        step_clk();
        advance = 1'b0;

        // STEP = 0 with out_port above LIMIT wraps, then holds
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h20);
        wr(2'd3, 32'h1);
        push(1, SEL_OUT, 32'h0, "step0_wrap_out");
        push(1, SEL_WRAP, 32'h1, "step0_wrap");
        push(2, SEL_OUT, 32'h0, "step0_hold_out");
        push(2, SEL_WRAP, 32'h0, "step0_hold_wrap");
        advance = 1'b1;
        step_clk();
        step_clk();
        advance = 1'b0;

        // Full-range modulo counter
        wr(2'd1, 32'h1);
        wr(2'd2, 32'h7FF);
        wr(2'd0, 32'h7FE);
        push(1, SEL_OUT, 32'h7FF, "mod_top_out");
        push(1, SEL_WRAP, 32'h0, "mod_top_wrap");
        push(2, SEL_OUT, 32'h0, "mod_roll_out");
        push(2, SEL_WRAP, 32'h1, "mod_roll_wrap");
        advance = 1'b1;
        step_clk();
        step_clk();
        advance = 1'b0;

        // LIMIT lowered below current address
        wr(2'd0, 32'h30);
        wr(2'd2, 32'h20);
        push(1, SEL_OUT, 32'h0, "limit_below_out");
        push(1, SEL_WRAP, 32'h1, "limit_below_wrap");
        advance = 1'b1;
        step_clk();
        advance = 1'b0;

        // irq_en write: implemented only with the irq build
        wr(2'd3, 32'h7);
`ifdef AVALON_ADDR_PIO_IRQ_EN
        rd(2'd3, 32'h5, "ctrl_irq_en");
`else
        rd(2'd3, 32'h1, "ctrl_no_irq_bit");
`endif
        wr(2'd2, 32'h7FF);
        wr(2'd0, 32'h7FF);
        push(1, SEL_WRAP, 32'h1, "irq_wrap");
`ifdef AVALON_ADDR_PIO_IRQ_EN
        push(1, SEL_IRQ, 32'h0, "irq_lags_sticky");
        push(2, SEL_IRQ, 32'h1, "irq_raised");
`endif
        advance = 1'b1;
        step_clk();
        advance = 1'b0;
        step_clk();
`ifdef AVALON_ADDR_PIO_IRQ_EN
        push(1, SEL_IRQ, 32'h1, "irq_still_high");
        push(2, SEL_IRQ, 32'h0, "irq_dropped");
`endif
        wr(2'd3, 32'h7);
        step_clk();

        // Asynchronous reset mid-stream
        wr(2'd0, 32'h7FF);
        advance = 1'b1;
        step_clk();
        step_clk();
        push(0, SEL_OUT, 32'h0, "midrst_out_port");
        push(0, SEL_WRAP, 32'h0, "midrst_wrap");
`ifdef AVALON_ADDR_PIO_IRQ_EN
        push(0, SEL_IRQ, 32'h0, "midrst_irq");
`endif
        reset = 1'b1;
        step_clk();
        advance = 1'b0;
        reset = 1'b0;
        rd(2'd1, 32'h1, "midrst_step");
        rd(2'd2, 32'h7FF, "midrst_limit");
        rd(2'd3, 32'h0, "midrst_ctrl");

        for (int i = 0; i < 10 && sb.size() > 0; i++) step_clk();
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
